fp_norm_round_pipe: RTL and testbench

Pipelined, parametrised normalise-and-round stage for the floating-point multiplier datapath, sitting between the significand multiplier / exponent adder and the exception/packing logic. Accepts the raw 2·(MAN_W+1)-bit significand product and the biased exponent sum, normalises by at most one position, applies the selected IEEE 754 rounding mode, and renormalises on rounding carry-out. It uses a two-stage valid/ready pipeline with full backpressure, and generalises the single-format, combinational, guard/sticky-only normaliser.

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_round_inc.sv | 32 +++
 rtl/fp_norm_round_pipe.sv | 135 +++++++++++++
 tb/tb_fp_norm_round_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier datapath.
//   rnd_mode_t   : IEEE 754 rounding-mode encoding carried alongside each beat.
//   EXP_W_DEF /
//   MAN_W_DEF    : default (binary32) field widths.
//   norm_stage_t : layout of one normalised beat in the default format
//                  (fraction, guard, sticky, exponent, sign, mode).
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    typedef enum logic [2:0] {
        RNE = 3'd0,   // nearest, ties to even
        RTZ = 3'd1,   // toward zero
        RUP = 3'd2,   // toward +inf
        RDN = 3'd3,   // toward -inf
        RMM = 3'd4    // nearest, ties away from zero
    } rnd_mode_t;

    typedef struct packed {
        logic [MAN_W_DEF-1:0] frac;
        logic                 guard;
        logic                 sticky;
        logic [EXP_W_DEF+1:0] exp;
        logic                 sign;
        rnd_mode_t            mode;
    } norm_stage_t;

endpackage

// File: rtl/fp_round_inc.sv
// Rounding increment decision, shared by the multiplier and adder datapaths.
// Ports:
//   lsb    in  : least significant kept fraction bit (L)
//   guard  in  : first bit below the kept fraction (G)
//   sticky in  : OR of all bits below the guard bit (S)
//   sign   in  : result sign, only matters for the directed modes
//   mode   in  : rounding mode
//   inc    out : 1 when the kept fraction must be incremented
module fp_round_inc
    import fp_pkg::*;
(
    input  logic      lsb,
    input  logic      guard,
    input  logic      sticky,
    input  logic      sign,
    input  rnd_mode_t mode,
    output logic      inc
);

    always_comb begin
        inc = guard & (lsb | sticky);
        case (mode)
            RTZ:     inc = 1'b0;
            RUP:     inc = ~sign & (guard | sticky);
            RDN:     inc = sign & (guard | sticky);
            RMM:     inc = guard;
            // RNE and the unused codes 5..7 all round to nearest-even
            default: inc = guard & (lsb | sticky);
        endcase
    end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise-and-round pipeline for the floating-point multiplier.
// Stage 1 normalises the raw significand product by at most one position and
// extracts guard/sticky; stage 2 applies the rounding mode and renormalises on
// a rounding carry-out. Full valid/ready backpressure, capacity two beats.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake
//   in_prod           : unsigned significand product, 2*(MAN_W+1) bits
//   in_exp            : biased exponent sum, EXP_W+2 bits
//   in_sign, in_rnd   : result sign and rounding mode, sampled per beat
//   out_valid/out_ready : output handshake
//   out_exp, out_man  : final exponent and rounded fraction (hidden bit dropped)
//   out_sign          : sign passed through
//   out_inexact       : guard|sticky was nonzero before rounding
module fp_norm_round_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*(MAN_W+1)-1:0]   in_prod,
    input  logic [EXP_W+1:0]         in_exp,
    input  logic                     in_sign,
    input  logic [2:0]               in_rnd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+1:0]         out_exp,
    output logic [MAN_W-1:0]         out_man,
    output logic                     out_sign,
    output logic                     out_inexact
);

    localparam int PW = 2 * (MAN_W + 1);
    localparam int XW = EXP_W + 2;

    typedef struct packed {
        logic [MAN_W-1:0] frac;
        logic             guard;
        logic             sticky;
        logic [XW-1:0]    exp;
        logic             sign;
        rnd_mode_t        mode;
    } stage_t;

    // Adds the rounding increment one bit wider so the carry-out is visible.
    function automatic logic [MAN_W:0] add_inc(input logic [MAN_W-1:0] frac,
                                                input logic inc);
        return {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    endfunction

    stage_t           norm_p0;
    stage_t           norm_p1;
    logic             vld_p1;
    logic             vld_p2;
    logic             ready_p2;
    logic             inc_p1;
    logic [MAN_W:0]   sum_p1;
    logic [XW-1:0]    exp_p2;
    logic [MAN_W-1:0] man_p2;
    logic             sign_p2;
    logic             inexact_p2;

    assign ready_p2 = ~vld_p2 | out_ready;
    assign in_ready = ~vld_p1 | ready_p2;

    // ---- stage 0 -> 1: normalise by at most one position ----
    // Products with both top bits clear (denormal operands) take the
    // no-shift path unchanged; there is deliberately no leading-zero count.
    always_comb begin
        norm_p0.sign = in_sign;
        norm_p0.mode = rnd_mode_t'(in_rnd);
        if (in_prod[PW-1]) begin
            norm_p0.frac   = in_prod[PW-2:MAN_W+1];
            norm_p0.guard  = in_prod[MAN_W];
            norm_p0.sticky = |in_prod[MAN_W-1:0];
            norm_p0.exp    = in_exp + XW'(1);
        end else begin
            norm_p0.frac   = in_prod[PW-3:MAN_W];
            norm_p0.guard  = in_prod[MAN_W-1];
            norm_p0.sticky = |in_prod[MAN_W-2:0];
            norm_p0.exp    = in_exp;
        end
    end

    // ---- stage 1 -> 2: round and renormalise on carry-out ----
    fp_round_inc u_round_inc (
        .lsb    (norm_p1.frac[0]),
        .guard  (norm_p1.guard),
        .sticky (norm_p1.sticky),
        .sign   (norm_p1.sign),
        .mode   (norm_p1.mode),
        .inc    (inc_p1)
    );

    assign sum_p1 = add_inc(norm_p1.frac, inc_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            norm_p1    <= '0;
            exp_p2     <= '0;
            man_p2     <= '0;
            sign_p2    <= 1'b0;
            inexact_p2 <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
                if (in_valid) norm_p1 <= norm_p0;
            end
            if (ready_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    // A carry out of the fraction means 1.111..1 rounded up to
                    // 10.000..0: the fraction becomes zero and the exponent bumps.
                    man_p2     <= sum_p1[MAN_W] ? '0 : sum_p1[MAN_W-1:0];
                    exp_p2     <= norm_p1.exp + XW'(sum_p1[MAN_W]);
                    sign_p2    <= norm_p1.sign;
                    inexact_p2 <= norm_p1.guard | norm_p1.sticky;
                end
            end
        end
    end

    assign out_valid   = vld_p2;
    assign out_exp     = exp_p2;
    assign out_man     = man_p2;
    assign out_sign    = sign_p2;
    assign out_inexact = inexact_p2;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Bench for fp_norm_round_pipe in the binary32 configuration: directed vectors,
// backpressure, asynchronous reset and randomized traffic against a numeric
// rounding model.
module tb_fp_norm_round_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_prod;
    logic [9:0]  in_exp;
    logic        in_sign;
    logic [2:0]  in_rnd;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_exp;
    logic [22:0] out_man;
    logic        out_sign;
    logic        out_inexact;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0]  e;
        logic [22:0] m;
        logic        s;
        logic        x;
    } beat_t;

    beat_t q[$];

    fp_norm_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_prod     (in_prod),
        .in_exp      (in_exp),
        .in_sign     (in_sign),
        .in_rnd      (in_rnd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_exp     (out_exp),
        .out_man     (out_man),
        .out_sign    (out_sign),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Numeric model: the value below the kept bits is compared against half
    // an ulp to decide the rounding, rather than working from G/S bits.
    function automatic beat_t model(input logic [47:0] p, input logic [9:0] e,
                                    input logic s, input logic [2:0] r);
        beat_t b;
        int sh;
        longint unsigned pv, rem, half, frac;
        bit inc;
        logic [9:0] ee;
        pv   = 64'(p);
        sh   = p[47] ? 24 : 23;
        rem  = pv & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        frac = (pv >> sh) % (64'd1 << 23);
        case (r)
            3'd1:    inc = 1'b0;
            3'd2:    inc = !s && (rem != 0);
            3'd3:    inc = s && (rem != 0);
            3'd4:    inc = rem >= half;
            default: inc = (rem > half) || (rem == half && (frac % 2) == 1);
        endcase
        ee   = e + (p[47] ? 10'd1 : 10'd0);
        frac = frac + 64'(inc);
        if (frac == (64'd1 << 23)) begin
            frac = 0;
            ee   = ee + 10'd1;
        end
        b.e = ee;
        b.m = frac[22:0];
        b.s = s;
        b.x = (rem != 0);
        return b;
    endfunction

    // Scoreboard: record accepted beats, compare every delivered beat in order.
    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_spurious_out", 1, 0);
                end else begin
                    b = q.pop_front();
                    chk("sb_exp", out_exp, b.e);
                    chk("sb_man", out_man, b.m);
                    chk("sb_sign", out_sign, b.s);
                    chk("sb_inexact", out_inexact, b.x);
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(in_prod, in_exp, in_sign, in_rnd));
        end
    end

    task automatic drive(input logic [47:0] p, input logic [9:0] e,
                         input logic s, input logic [2:0] r);
        in_prod  = p;
        in_exp   = e;
        in_sign  = s;
        in_rnd   = r;
        in_valid = 1'b1;
    endtask

    // One beat through an idle pipeline with out_ready high; checks the
    // two-cycle latency and the result against hand-derived constants.
    task automatic directed(input string tag, input logic [47:0] p, input logic [9:0] e,
                            input logic s, input logic [2:0] r,
                            input logic [9:0] ee, input logic [22:0] em, input logic ex);
        @(posedge clk); #1;
        drive(p, e, s, r);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_not_yet_valid"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_exp"}, out_exp, ee);
        chk({tag, "_man"}, out_man, em);
        chk({tag, "_inexact"}, out_inexact, ex);
        chk({tag, "_sign"}, out_sign, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rr;
        logic [47:0] p;
        int cls;
        int waited;

        rst = 1'b1;
        in_valid = 1'b0;
        in_prod = '0;
        in_exp = '0;
        in_sign = 1'b0;
        in_rnd = 3'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_exp", out_exp, 0);
        chk("rst_out_man", out_man, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        directed("exact_norm", 48'h8000_0000_0000, 10'd127, 1'b0, 3'd0, 10'd128, 23'h0, 1'b0);
        directed("tie_even", 48'h4000_0040_0000, 10'd127, 1'b0, 3'd0, 10'd127, 23'h0, 1'b1);
        directed("tie_odd", 48'h4000_00C0_0000, 10'd127, 1'b0, 3'd0, 10'd127, 23'h2, 1'b1);
        directed("tie_mode7", 48'h4000_00C0_0000, 10'd127, 1'b0, 3'd7, 10'd127, 23'h2, 1'b1);
        directed("tie_rmm", 48'h4000_0040_0000, 10'd127, 1'b0, 3'd4, 10'd127, 23'h1, 1'b1);
        directed("carry_rne", 48'h7FFF_FFC0_0000, 10'd127, 1'b0, 3'd0, 10'd128, 23'h0, 1'b1);
        directed("carry_rtz", 48'h7FFF_FFC0_0000, 10'd127, 1'b0, 3'd1, 10'd127, 23'h7FFFFF, 1'b1);
        directed("sticky_rup_pos", 48'h4000_0000_0001, 10'd127, 1'b0, 3'd2, 10'd127, 23'h1, 1'b1);
        directed("sticky_rdn_pos", 48'h4000_0000_0001, 10'd127, 1'b0, 3'd3, 10'd127, 23'h0, 1'b1);
        directed("sticky_rdn_neg", 48'h4000_0000_0001, 10'd127, 1'b1, 3'd3, 10'd127, 23'h1, 1'b1);
        directed("exp_wrap", 48'h8000_0000_0000, 10'h3FF, 1'b0, 3'd0, 10'h000, 23'h0, 1'b0);

        // Backpressure: three beats offered while the output is stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(48'h4000_0080_0000, 10'd10, 1'b0, 3'd0);
        @(negedge clk);
        chk("bp_accept_a", in_ready, 1);
        @(posedge clk); #1;
        drive(48'h4000_0100_0000, 10'd11, 1'b0, 3'd0);
        @(negedge clk);
        chk("bp_accept_b", in_ready, 1);
        @(posedge clk); #1;
        drive(48'h4000_0180_0000, 10'd12, 1'b1, 3'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_full_in_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_man", out_man, 1);
            chk("bp_hold_exp", out_exp, 10);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_order_a", out_man, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_order_b", out_man, 2);
        @(negedge clk);
        chk("bp_order_c", out_man, 3);
        chk("bp_order_c_sign", out_sign, 1);

        // Asynchronous reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(48'h8000_0180_0000, 10'd50, 1'b1, 3'd2);
        @(posedge clk); #1;
        drive(48'h4000_0280_0001, 10'd60, 1'b1, 3'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_in_ready", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_exp", out_exp, 0);
        chk("async_rst_man", out_man, 0);
        chk("async_rst_sign", out_sign, 0);
        chk("async_rst_inexact", out_inexact, 0);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);
        directed("after_rst", 48'h8000_0000_0000, 10'd1, 1'b1, 3'd0, 10'd2, 23'h0, 1'b0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            rr  = {$urandom(), $urandom()};
            cls = int'($urandom_range(0, 3));
            case (cls)
                0:       p = {1'b1, rr[46:0]};
                1:       p = {2'b01, rr[45:0]};
                2:       p = {2'b00, rr[45:0]};
                default: p = {2'b01, 23'h7FFFFF, (rr[0] ? 23'h400000 : rr[22:0])};
            endcase
            in_prod  = p;
            in_exp   = rr[57:48];
            in_sign  = rr[58];
            in_rnd   = 3'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("final_drain_empty", q.size(), 0);
        @(negedge clk);
        chk("final_idle_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
